// File: rtl/bridge_pkg.sv
// Shared definitions for the APB master controller.
//   - fsm_state_t   : internal controller states
//   - APB_ST_*      : external 2-bit status encodings driven on apb_state
//   - TIMEOUT_CYC   : ACCESS wait-cycle limit before a transfer is forced to end
//   - PKT_*         : bit positions of the fields inside a 64-bit command packet
//   - sel_onehot()  : slave-select index to one-hot psel vector
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_PUSH   = 3'd4
  } fsm_state_t;

  localparam logic [1:0] APB_ST_IDLE   = 2'd0;
  localparam logic [1:0] APB_ST_SETUP  = 2'd1;
  localparam logic [1:0] APB_ST_ACCESS = 2'd2;
  localparam logic [1:0] APB_ST_BUSY   = 2'd3;

  localparam logic [7:0] TIMEOUT_CYC = 8'd255;

  localparam int PKT_WRITE_BIT = 63;
  localparam int PKT_SEL_HI    = 41;
  localparam int PKT_SEL_LO    = 40;
  localparam int PKT_ADDR_HI   = 39;
  localparam int PKT_ADDR_LO   = 32;
  localparam int PKT_DATA_HI   = 31;
  localparam int PKT_DATA_LO   = 0;

  function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/apb_master_ctrl.sv
// APB master controller: pops command packets from a write FIFO, runs one APB
// transfer per packet and, for reads, pushes {pslverr, 31'b0, prdata} into a
// read FIFO. Transfers that see no pready within the timeout end with an error.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   ctrl_en             : 0 blocks fetching of new commands
//   wfifo_empty/ren     : write-FIFO empty flag / pop strobe
//   wfifo_rdata         : command packet (valid the cycle after wfifo_ren)
//   rfifo_full/wen/wdata: read-FIFO full flag / push strobe / push data
//   psel..pslverr       : APB master interface
//   apb_state           : IDLE=0, SETUP=1, ACCESS=2, BUSY=3 (FETCH or PUSH)
//   err_flag, err_clr   : sticky error flag and its clear
module apb_master_ctrl
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_en,
  input  logic        wfifo_empty,
  output logic        wfifo_ren,
  input  logic [63:0] wfifo_rdata,
  input  logic        rfifo_full,
  output logic        rfifo_wen,
  output logic [63:0] rfifo_wdata,
  output logic [3:0]  psel,
  output logic        penable,
  output logic        pwrite,
  output logic [7:0]  paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  output logic [1:0]  apb_state,
  output logic        err_flag,
  input  logic        err_clr
);

  // The counter starts at 0 on the first ACCESS cycle, so it holds
  // TIMEOUT_CYC-1 during the last allowed one; it reaches TIMEOUT_CYC as the
  // forced completion takes effect.
  localparam logic [7:0] TIMEOUT_LAST = TIMEOUT_CYC - 8'd1;

  fsm_state_t  state_reg, state_next;
  logic        cmd_write_reg;
  logic [1:0]  cmd_sel_reg;
  logic [7:0]  cmd_addr_reg;
  logic [31:0] cmd_data_reg;
  logic [7:0]  wait_cnt_reg;
  logic [63:0] rdata_reg;
  logic        err_reg;

  logic        access_done;
  logic        access_err;
  logic        timeout;

  // Packet bits outside the defined fields carry no meaning.
  logic        unused_pkt_bits;
  assign unused_pkt_bits = ^wfifo_rdata[62:42];

  always_comb begin
    state_next  = state_reg;
    wfifo_ren   = 1'b0;
    rfifo_wen   = 1'b0;
    access_done = 1'b0;
    access_err  = 1'b0;
    timeout     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // rst gating keeps the pop strobe low while reset is held.
        if (ctrl_en && !wfifo_empty && !rst) begin
          wfifo_ren  = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: state_next = ST_SETUP;
      ST_SETUP: state_next = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          access_done = 1'b1;
          access_err  = pslverr;
        end else if (wait_cnt_reg == TIMEOUT_LAST) begin
          access_done = 1'b1;
          access_err  = 1'b1;
          timeout     = 1'b1;
        end
        if (access_done) begin
          state_next = cmd_write_reg ? ST_IDLE : ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (!rfifo_full) begin
          rfifo_wen  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cmd_write_reg <= 1'b0;
      cmd_sel_reg   <= 2'd0;
      cmd_addr_reg  <= 8'd0;
      cmd_data_reg  <= 32'd0;
      wait_cnt_reg  <= 8'd0;
      rdata_reg     <= 64'd0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (state_reg == ST_FETCH) begin
        cmd_write_reg <= wfifo_rdata[PKT_WRITE_BIT];
        cmd_sel_reg   <= wfifo_rdata[PKT_SEL_HI:PKT_SEL_LO];
        cmd_addr_reg  <= wfifo_rdata[PKT_ADDR_HI:PKT_ADDR_LO];
        cmd_data_reg  <= wfifo_rdata[PKT_DATA_HI:PKT_DATA_LO];
      end

      if (state_reg == ST_SETUP) begin
        wait_cnt_reg <= 8'd0;
      end else if (state_reg == ST_ACCESS && !pready) begin
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end

      // Read data is held unchanged for as long as the read FIFO stays full.
      if (access_done && !cmd_write_reg) begin
        rdata_reg <= timeout ? {1'b1, 63'd0} : {pslverr, 31'd0, prdata};
      end

      // A new error in the same cycle as err_clr keeps the flag set.
      if (access_done && access_err) begin
        err_reg <= 1'b1;
      end else if (err_clr) begin
        err_reg <= 1'b0;
      end
    end
  end

  // APB outputs decode straight from the state register so reset forces them
  // low immediately.
  assign psel        = (state_reg == ST_SETUP || state_reg == ST_ACCESS) ?
                       sel_onehot(cmd_sel_reg) : 4'd0;
  assign penable     = (state_reg == ST_ACCESS);
  assign pwrite      = cmd_write_reg;
  assign paddr       = cmd_addr_reg;
  assign pwdata      = cmd_data_reg;
  assign rfifo_wdata = rdata_reg;
  assign err_flag    = err_reg;

  always_comb begin
    apb_state = APB_ST_BUSY;
    case (state_reg)
      ST_IDLE:   apb_state = APB_ST_IDLE;
      ST_SETUP:  apb_state = APB_ST_SETUP;
      ST_ACCESS: apb_state = APB_ST_ACCESS;
      default:   apb_state = APB_ST_BUSY;
    endcase
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
module tb_apb_master_ctrl;
  import bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctrl_en = 1'b0;
  logic        err_clr = 1'b0;
  logic        rfifo_full = 1'b0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic [31:0] prdata = 32'd0;
  logic [63:0] wfifo_rdata = 64'd0;
  logic        wfifo_empty;
  logic        wfifo_ren, rfifo_wen, penable, pwrite, err_flag;
  logic [63:0] rfifo_wdata;
  logic [3:0]  psel;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [1:0]  apb_state;

  apb_master_ctrl dut (
    .clk(clk), .rst(rst), .ctrl_en(ctrl_en),
    .wfifo_empty(wfifo_empty), .wfifo_ren(wfifo_ren), .wfifo_rdata(wfifo_rdata),
    .rfifo_full(rfifo_full), .rfifo_wen(rfifo_wen), .rfifo_wdata(rfifo_wdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .apb_state(apb_state), .err_flag(err_flag), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [1:0]  sel;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          waitc;   // ACCESS cycles with pready=0 before the slave answers
    logic [31:0] rdata;
    logic        err;
  } txn_t;

  txn_t        exp_apb[$];
  logic [63:0] exp_push[$];
  logic [63:0] wq[$];
  int          push_cnt = 0;
  int          pop_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  int          ren_total = 0;
  int          full_mode = 0;  // 0: not full, 1: full, 2: random

  assign wfifo_empty = (push_cnt == pop_cnt);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  task automatic issue(input logic w, input logic [1:0] sel, input logic [7:0] addr,
                       input logic [31:0] data, input int waitc, input logic [31:0] rd,
                       input logic err);
    txn_t t;
    logic [63:0] pkt;
    t.write = w; t.sel = sel; t.addr = addr; t.wdata = data;
    t.waitc = waitc; t.rdata = rd; t.err = err;
    pkt = 64'd0;
    pkt[63] = w;
    pkt[62:42] = 21'($urandom);
    pkt[41:40] = sel;
    pkt[39:32] = addr;
    pkt[31:0] = data;
    exp_apb.push_back(t);
    if (!w) exp_push.push_back((waitc >= 255) ? 64'h8000_0000_0000_0000 : {err, 31'd0, rd});
    wq.push_back(pkt);
    push_cnt++;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (n < budget && !(wq.size() == 0 && exp_apb.size() == 0 &&
                           exp_push.size() == 0 && apb_state == APB_ST_IDLE)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL drain_%s actual=pending required=drained", name);
    end
  endtask

  // Write-FIFO model: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    if (wfifo_ren && wq.size() > 0) begin
      wfifo_rdata <= wq.pop_front();
      pop_cnt <= pop_cnt + 1;
    end
  end

  // Read-FIFO full flag, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    rfifo_full = (full_mode == 1) || (full_mode == 2 && ($urandom % 3 == 0));
  end

  // Slave model plus scoreboard monitor, evaluated on the falling edge.
  int   acc_cnt = 0;
  logic pend_end = 1'b0, pend_err = 1'b0, clr_prev = 1'b0, exp_err = 1'b0;
  logic ren_prev = 1'b0, wen_prev = 1'b0;

  always @(negedge clk) begin
    txn_t t;
    logic [63:0] ep;
    if (rst) begin
      acc_cnt = 0; pend_end = 0; pend_err = 0; clr_prev = 0; exp_err = 0;
      ren_prev = 0; wen_prev = 0; pready = 0; pslverr = 0;
    end else begin
      if (pend_err) exp_err = 1'b1;
      else if (clr_prev) exp_err = 1'b0;
      chk("err_flag", err_flag, exp_err);
      if (pend_end) chk("idle_after_done", {psel, penable}, 5'd0);
      pend_end = 0;
      pend_err = 0;

      if (wfifo_ren) begin
        ren_total++;
        chk("ren_single", ren_prev, 0);
      end
      ren_prev = wfifo_ren;

      if (rfifo_wen) begin
        chk("wen_single", wen_prev, 0);
        chk("wen_not_full", rfifo_full, 0);
        if (exp_push.size() == 0) fail_now("unexpected_push");
        else begin
          ep = exp_push.pop_front();
          chk("rfifo_wdata", rfifo_wdata, ep);
          $display("push data=0x%016h", rfifo_wdata);
        end
      end
      wen_prev = rfifo_wen;

      pready = 0;
      pslverr = 0;
      prdata = $urandom;
      if (psel != 4'd0) begin
        if (exp_apb.size() == 0) fail_now("unexpected_apb");
        else begin
          t = exp_apb[0];
          chk("psel", psel, sel_onehot(t.sel));
          chk("paddr", paddr, t.addr);
          chk("pwrite", pwrite, t.write);
          chk("pwdata", pwdata, t.wdata);
          if (penable) begin
            if (acc_cnt == t.waitc) begin
              pready = 1;
              prdata = t.rdata;
              pslverr = t.err;
            end
            if (pready || acc_cnt == 254) begin
              pend_end = 1;
              pend_err = pready ? t.err : 1'b1;
              void'(exp_apb.pop_front());
              $display("apb %s sel=%0d addr=0x%02h wdata=0x%08h acc=%0d err=%0d",
                       t.write ? "wr" : "rd", t.sel, t.addr, t.wdata, acc_cnt + 1, pend_err);
            end
            acc_cnt++;
          end else begin
            acc_cnt = 0;
          end
        end
      end else if (penable) begin
        fail_now("penable_without_psel");
      end
      clr_prev = err_clr;
    end
  end

  initial begin
    int seen, cnt, lcnt, found;
    logic [63:0] held;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_wfifo_ren", wfifo_ren, 0);
    chk("rst_rfifo_wen", rfifo_wen, 0);
    chk("rst_rfifo_wdata", rfifo_wdata, 0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_apb_state", apb_state, APB_ST_IDLE);
    @(posedge clk); #1;
    rst = 0;
    ctrl_en = 1;

    // Directed write with pready tied high: cycle-by-cycle trace
    @(posedge clk); #1;
    issue(1'b1, 2'd2, 8'h10, 32'hA5A5_0001, 0, 32'd0, 1'b0);
    @(negedge clk);
    chk("w_ren", wfifo_ren, 1);
    chk("w_idle", apb_state, APB_ST_IDLE);
    @(negedge clk);
    chk("w_fetch", apb_state, APB_ST_BUSY);
    @(negedge clk);
    chk("w_setup", apb_state, APB_ST_SETUP);
    chk("w_setup_psel", psel, 4'b0100);
    chk("w_setup_penable", penable, 0);
    @(negedge clk);
    chk("w_access", apb_state, APB_ST_ACCESS);
    chk("w_access_penable", penable, 1);
    chk("w_access_pwdata", pwdata, 32'hA5A5_0001);
    @(negedge clk);
    chk("w_back_idle", apb_state, APB_ST_IDLE);
    chk("w_back_psel", {psel, penable}, 0);

    // Directed read with 3 wait cycles
    @(posedge clk); #1;
    issue(1'b0, 2'd0, 8'h18, $urandom, 3, 32'h3, 1'b0);
    wait_drain(100, "read3");

    // Read blocked by a full read FIFO
    full_mode = 1;
    @(posedge clk); #2;
    issue(1'b0, 2'd1, 8'h22, $urandom, 1, 32'hDEAD_BEEF, 1'b0);
    seen = 0;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(negedge clk);
      if (penable) seen = 1;
      if (seen == 1 && apb_state == APB_ST_BUSY) found = 1;
    end
    if (found == 0) fail_now("push_not_reached");
    held = 64'h0000_0000_DEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("full_hold_state", apb_state, APB_ST_BUSY);
      chk("full_hold_wen", rfifo_wen, 0);
      chk("full_hold_data", rfifo_wdata, held);
    end
    full_mode = 0;
    wait_drain(50, "full");

    // Error and clear in the same cycle: the error wins
    @(posedge clk); #1;
    err_clr = 1;
    issue(1'b1, 2'd3, 8'h40, $urandom, 0, 32'd0, 1'b1);
    wait_drain(50, "set_wins");
    @(posedge clk); #1;
    err_clr = 0;

    // Randomized traffic
    full_mode = 2;
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom), 2'($urandom), 8'($urandom), $urandom, int'($urandom % 4),
            $urandom, ($urandom % 5 == 0));
      repeat ($urandom % 3) @(posedge clk);
      #1;
    end
    wait_drain(3000, "random");
    full_mode = 0;
    @(posedge clk); #1;
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    @(negedge clk);
    chk("clr_after_random", err_flag, 0);

    // Timeout on a read with pready stuck low
    @(posedge clk); #1;
    issue(1'b0, 2'd2, 8'h33, $urandom, 300, 32'd0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (penable) cnt++;
    end
    chk("timeout_access_cycles", cnt, 255);
    wait_drain(50, "timeout");
    chk("timeout_err_flag", err_flag, 1);
    @(posedge clk); #1;
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    @(negedge clk);
    chk("timeout_err_clr", err_flag, 0);

    // ctrl_en dropped during the second of four writes
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) issue(1'b1, 2'(i), 8'(8'h60 + i), $urandom, 1, 32'd0, 1'b0);
    lcnt = 0;
    for (int i = 0; i < 50 && lcnt < 2; i++) begin
      @(negedge clk);
      if (wfifo_ren) lcnt++;
    end
    @(posedge clk); #1;
    ctrl_en = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (wfifo_ren) lcnt++;
    end
    chk("ctrl_en_ren_count", lcnt, 2);
    chk("ctrl_en_pending", exp_apb.size(), 2);
    chk("ctrl_en_idle", apb_state, APB_ST_IDLE);
    ctrl_en = 1;
    wait_drain(100, "ctrl_en");

    // Reset asserted in ACCESS
    @(posedge clk); #1;
    issue(1'b0, 2'd1, 8'h55, $urandom, 50, 32'd0, 1'b0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (penable) found = 1;
    end
    if (found == 0) fail_now("access_not_reached");
    #2;
    rst = 1;
    #1;
    chk("arst_psel", psel, 0);
    chk("arst_penable", penable, 0);
    chk("arst_apb_state", apb_state, APB_ST_IDLE);
    exp_apb.delete();
    exp_push.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (psel != 0 || wfifo_ren || rfifo_wen || apb_state != APB_ST_IDLE) cnt++;
    end
    chk("arst_no_replay", cnt, 0);

    chk("final_apb_queue", exp_apb.size(), 0);
    chk("final_push_queue", exp_push.size(), 0);
    $display("pops seen=%0d", ren_total);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
